// File: rtl/noise_gen_pkg.sv
// rtl/noise_gen_pkg.sv - shared widths and state encoding for the sqrt evaluator
// Optional feature macro: SQRT_ROUND_EN (adds the ROUND state).
package noise_gen_pkg;

  localparam int E_W       = 31;
  localparam int F_W       = 20;
  localparam int RAD_W     = 40;
  localparam int SQRT_ITER = 20;
  // Remainder never exceeds 2*root, so two bits above the root width suffice.
  localparam int REM_W     = F_W + 2;
  localparam int CNT_W     = 5;

`ifdef SQRT_ROUND_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ROUND = 2'd3
  } sqrt_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sqrt_state_t;
`endif

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one restoring square-root digit step (combinational)
module sqrt_step
  import noise_gen_pkg::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic [F_W-1:0]   i_root,
  input  logic [1:0]       i_bits,
  output logic [REM_W-1:0] o_rem,
  output logic [F_W-1:0]   o_root
);

  logic [REM_W+1:0] w_shifted;
  logic [REM_W+1:0] w_trial;
  logic [REM_W+1:0] w_diff;
  logic             w_unused;

  assign w_shifted = {i_rem, i_bits};
  assign w_trial   = {2'b00, i_root, 2'b01};
  assign w_diff    = w_shifted - w_trial;

  // Top bits of the difference are zero whenever it is kept; root MSB is
  // always zero before the final shift.
  assign w_unused = ^{w_diff[REM_W+1:REM_W], i_root[F_W-1]};

  // Trial subtract: keep the difference and append a 1 if it fits, else restore.
  always_comb begin
    o_rem  = w_shifted[REM_W-1:0];
    o_root = {i_root[F_W-2:0], 1'b0};
    if (w_shifted >= w_trial) begin
      o_rem  = w_diff[REM_W-1:0];
      o_root = {i_root[F_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sqrt_eval.sv
// rtl/sqrt_eval.sv - iterative sqrt(2*e) evaluator, u4.16 result
// Optional feature macro: SQRT_ROUND_EN (round-to-nearest via extra ROUND state).
module sqrt_eval
  import noise_gen_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [E_W-1:0] e_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [F_W-1:0] f_out
);

  sqrt_state_t      r_state;
  sqrt_state_t      w_next;
  logic [RAD_W-1:0] r_rad;
  logic [F_W-1:0]   r_root;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [REM_W-1:0] w_step_rem;
  logic [F_W-1:0]   w_step_root;
  logic             w_accept;
  logic             w_last_iter;
  logic             w_unused;

  // Bits 30:28 of the operand carry no information from the log stage.
  assign w_unused    = ^e_in[E_W-1:28];
  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_last_iter = (r_cnt == CNT_W'(SQRT_ITER - 1));
  assign f_out       = r_root;

  sqrt_step u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_rad[RAD_W-1:RAD_W-2]),
    .o_rem  (w_step_rem),
    .o_root (w_step_root)
  );

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_CALC;
      end
      ST_CALC: begin
`ifdef SQRT_ROUND_EN
        if (w_last_iter) w_next = ST_ROUND;
`else
        if (w_last_iter) w_next = ST_DONE;
`endif
      end
`ifdef SQRT_ROUND_EN
      ST_ROUND: w_next = ST_DONE;
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: capture operand, iterate one root bit per cycle, optional rounding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rad  <= '0;
      r_root <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rad  <= {3'b000, e_in[27:0], 9'b0};
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
          end
        end
        ST_CALC: begin
          r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
          r_root <= w_step_root;
          r_rem  <= w_step_rem;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
`ifdef SQRT_ROUND_EN
        // rem > root means sqrt lies at or above root + 0.5.
        ST_ROUND: begin
          if (({2'b00, r_root} < r_rem) && (r_root != {F_W{1'b1}})) begin
            r_root <= r_root + F_W'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_eval.sv
// tb/tb_sqrt_eval.sv - directed and random self-checking bench for sqrt_eval
module tb_sqrt_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] e_in;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] f_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SQRT_ROUND_EN
  localparam int          LAT     = 21;
  localparam logic [19:0] EXP_ONE = 20'h16A0A;
  localparam logic [19:0] EXP_MAX = 20'h5A828;
  localparam logic [19:0] EXP_LSB = 20'h00017;
`else
  localparam int          LAT     = 20;
  localparam logic [19:0] EXP_ONE = 20'h16A09;
  localparam logic [19:0] EXP_MAX = 20'h5A827;
  localparam logic [19:0] EXP_LSB = 20'h00016;
`endif

  sqrt_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e_in      (e_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ref_sqrt(input logic [30:0] e);
    longint n, lo, hi, mid;
    n  = longint'(e[27:0]) * 512;
    lo = 0;
    hi = 1048575;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else                hi = mid - 1;
    end
`ifdef SQRT_ROUND_EN
    if ((n - lo * lo) > lo && lo < 1048575) lo = lo + 1;
`endif
    return 20'(lo);
  endfunction

  // Present one operand, wait for the result; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [30:0] e, input logic rdy,
                        output logic [19:0] f, output int lat, output bit ok);
    ok        = 1'b0;
    lat       = -1;
    f         = '0;
    in_valid  = 1'b1;
    e_in      = e;
    out_ready = rdy;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    @(negedge clk);
    in_valid = 1'b0;
    e_in     = 31'($urandom);
    ok       = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) begin
        ok  = 1'b1;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    f = f_out;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b1;
    e_in      = 31'h2000000;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    n_checks++;
    if (f_out !== 20'h0) begin
      n_fail++; $display("FAIL reset_f_out got=%h want=00000", f_out);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_no_capture in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_vectors;
    logic [30:0] ev [7];
    logic [19:0] fv [7];
    logic [19:0] f;
    int          lat;
    bit          ok;
    ev[0] = 31'h0000000;  fv[0] = 20'h00000;
    ev[1] = 31'h0800000;  fv[1] = 20'h10000;
    ev[2] = 31'h2000000;  fv[2] = 20'h20000;
    ev[3] = 31'h1000000;  fv[3] = EXP_ONE;
    ev[4] = 31'h72000000; fv[4] = 20'h20000;
    ev[5] = 31'h0FFFFFFF; fv[5] = EXP_MAX;
    ev[6] = 31'h0000001;  fv[6] = EXP_LSB;
    for (int i = 0; i < 7; i++) begin
      run_op(ev[i], 1'b1, f, lat, ok);
      n_checks++;
      if (ok !== 1'b1) begin
        n_fail++; $display("FAIL vec%0d_timeout got=%b want=1", i, ok);
      end
      n_checks++;
      if (lat !== LAT) begin
        n_fail++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, LAT);
      end
      n_checks++;
      if (f !== fv[i]) begin
        n_fail++; $display("FAIL vec%0d_f_out e=%h got=%h want=%h", i, ev[i], f, fv[i]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_hold;
    logic [19:0] f;
    int          lat;
    bit          ok;
    run_op(31'h0800000, 1'b0, f, lat, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL hold_timeout got=%b want=1", ok);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      e_in     = 31'($urandom);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_out_valid cyc=%0d got=%b want=1", i, out_valid);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_in_ready cyc=%0d got=%b want=0", i, in_ready);
      end
      n_checks++;
      if (f_out !== 20'h10000) begin
        n_fail++; $display("FAIL hold_f_out cyc=%0d got=%h want=10000", i, f_out);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_no_capture in_ready got=%b want=1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL release_out_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_mid_reset;
    logic [19:0] f;
    int          lat;
    bit          ok;
    in_valid  = 1'b1;
    e_in      = 31'h1000000;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_out_valid got=%b want=0", out_valid);
    end
    n_checks++;
    if (f_out !== 20'h0) begin
      n_fail++; $display("FAIL midreset_f_out got=%h want=00000", f_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_in_ready got=%b want=1", in_ready);
    end
    run_op(31'h2000000, 1'b0, f, lat, ok);
    n_checks++;
    if (ok !== 1'b1 || f !== 20'h20000) begin
      n_fail++; $display("FAIL after_reset_f_out got=%h ok=%b want=20000", f, ok);
    end
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (f_out !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL done_reset got f=%h ov=%b ir=%b want f=00000 ov=0 ir=1",
                         f_out, out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [30:0] e;
    logic [19:0] f;
    logic [19:0] exp_f;
    int          lat;
    bit          ok;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      e     = 31'($urandom);
      exp_f = ref_sqrt(e);
      run_op(e, 1'b1, f, lat, ok);
      n_checks++;
      if (ok !== 1'b1 || f !== exp_f) begin
        n_fail++; $display("FAIL random%0d e=%h got=%h ok=%b want=%h", i, e, f, ok, exp_f);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    e_in      = '0;
    @(negedge clk);
    test_reset;
    test_vectors;
    test_hold;
    test_mid_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
